// File: rtl/writeback_unit.sv
// Writeback stage: retires single-cycle results, sequences loads and ecall input,
// and drives a registered register-file write port.
module writeback_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] pc,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    input  logic        ecall_in,
    input  logic [31:0] io_data,
    input  logic        io_valid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        Write,
    output logic [31:0] WriteData,
    output logic [4:0]  WriteReg,
    output logic        busy
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    typedef enum logic [1:0] {IDLE, MEM_WAIT, IO_WAIT} state_t;
    state_t state;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [31:0] u_imm;
    logic [2:0]  ld_f3;
    logic [4:0]  ld_rd;
    logic [1:0]  ld_off;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign u_imm  = {instruction[31:12], 12'b0};

    logic        sc_hit;
    logic [31:0] sc_data;
    always_comb begin
        sc_hit  = 1'b0;
        sc_data = '0;
        case (opcode)
            OP_R, OP_IMM:     begin sc_hit = 1'b1; sc_data = alu_result;   end
            OP_JAL, OP_JALR:  begin sc_hit = 1'b1; sc_data = pc + 32'd4;   end
            OP_LUI:           begin sc_hit = 1'b1; sc_data = u_imm;        end
            OP_AUIPC:         begin sc_hit = 1'b1; sc_data = pc + u_imm;   end
            default: ;
        endcase
    end

    // Lane select on the aligned word; halfword select ignores addr[0].
    logic [31:0] shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    always_comb begin
        shifted = mem_rdata >> {ld_off, 3'b000};
        ld_byte = shifted[7:0];
        ld_half = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ld_f3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'b0, ld_byte};
            3'b101:  ld_data = {16'b0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            Write     <= 1'b0;
            WriteData <= '0;
            WriteReg  <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            ld_f3     <= '0;
            ld_rd     <= '0;
            ld_off    <= '0;
        end else begin
            Write   <= 1'b0;
            mem_req <= 1'b0;
            case (state)
                IDLE: if (valid) begin
                    if (sc_hit) begin
                        // x0 writes are dropped; data/reg only move with a real strobe.
                        if (rd != 5'd0) begin
                            Write     <= 1'b1;
                            WriteData <= sc_data;
                            WriteReg  <= rd;
                        end
                    end else if (opcode == OP_LOAD) begin
                        mem_req  <= 1'b1;
                        mem_addr <= alu_result;
                        busy     <= 1'b1;
                        ld_f3    <= instruction[14:12];
                        ld_rd    <= rd;
                        ld_off   <= alu_result[1:0];
                        state    <= MEM_WAIT;
                    end else if (opcode == OP_SYS && ecall_in) begin
                        busy  <= 1'b1;
                        state <= IO_WAIT;
                    end
                end
                MEM_WAIT: if (mem_rvalid) begin
                    if (ld_rd != 5'd0) begin
                        Write     <= 1'b1;
                        WriteData <= ld_data;
                        WriteReg  <= ld_rd;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                IO_WAIT: if (io_valid) begin
                    Write     <= 1'b1;
                    WriteData <= io_data;
                    WriteReg  <= 5'd10;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
